// File: rtl/mem_ctrl_pkg.sv
// Shared constants and state encoding for the sequential memory-access controller.
package mem_ctrl_pkg;

  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter: cleared while idle, counts wait cycles without ack, flags the last one.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned   CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires on the edge where the count would reach TIMEOUT, so an ack in that cycle still wins.
  assign expired_o = enable_i && !clear_i && (cnt_q == CntLast);

endmodule

// File: rtl/mem_access_ctrl.sv
// Serialises fetch / LDR / STR onto one req/ack memory bus with wait-state timeout.
module mem_access_ctrl #(
  parameter int unsigned             ADDR_W  = 32,
  parameter int unsigned             DATA_W  = 32,
  parameter int unsigned             OPC_W   = 4,
  parameter logic [OPC_W-1:0]        OP_LDR  = OPC_W'(4'b1101),
  parameter logic [OPC_W-1:0]        OP_STR  = OPC_W'(4'b1110),
  parameter int unsigned             TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [OPC_W-1:0]  op_code,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [DATA_W-1:0] sr2,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] instr,
  output logic              instr_vld,
  output logic [DATA_W-1:0] ldr_data,
  output logic              ldr_vld,
  output logic              str_done,
  output logic              err
);

  import mem_ctrl_pkg::*;

  state_e state_q, state_d;
  logic   is_ldr_q;
  logic   busy, accept, in_ldr, in_str, expired;

  assign busy   = (state_q != IDLE);
  assign accept = cpu_valid && !busy;
  assign in_ldr = (op_code == OP_LDR);
  assign in_str = (op_code == OP_STR);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (!busy),
    .enable_i  (busy && !mem_ack),
    .expired_o (expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: ack or expiry returns to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          state_d = in_str ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack || expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cpu_ready = (state_q == IDLE);
  end

  // Request registers, result capture and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      is_ldr_q  <= 1'b0;
      instr     <= '0;
      instr_vld <= 1'b0;
      ldr_data  <= '0;
      ldr_vld   <= 1'b0;
      str_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      instr_vld <= 1'b0;
      ldr_vld   <= 1'b0;
      str_done  <= 1'b0;
      if (accept) begin
        mem_req   <= 1'b1;
        mem_rw    <= in_str ? RW_WRITE : RW_READ;
        mem_addr  <= (in_ldr || in_str) ? sr1 : pc;
        mem_wdata <= in_str ? sr2 : '0;
        is_ldr_q  <= in_ldr;
        err       <= 1'b0;
      end else if (busy && mem_ack) begin
        mem_req <= 1'b0;
        if (state_q == WR_WAIT) begin
          str_done <= 1'b1;
        end else if (is_ldr_q) begin
          ldr_data <= mem_rdata;
          ldr_vld  <= 1'b1;
        end else begin
          instr     <= mem_rdata;
          instr_vld <= 1'b1;
        end
      end else if (expired) begin
        mem_req <= 1'b0;
        err     <= 1'b1;
      end
    end
  end

endmodule
